// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the clocked data memory:
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL)
//   - request/response FSM state enum
//   - lane_enable : byte-lane write enables for a size/offset pair
//   - load_extend : lane selection plus sign/zero extension of a read word
// Byte order is little-endian: lane 0 is bits [7:0].
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Halfwords occupy lanes {addr[1],0} and {addr[1],1}; an illegal size
    // enables no lanes so it can never disturb the array.
    function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  addr_lo,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = is_unsigned ? {16'h0000, h}   : {{16{h[15]}}, h};
            SZ_WORD: r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational steering between the 32-bit array and the
// right-aligned pipeline data.
// Ports:
//   wr_addr_lo_i  in  2   byte offset of the store
//   wr_size_i     in  2   store size encoding
//   wr_data_i     in  32  right-aligned store data
//   wr_be_o       out 4   byte-lane write enables
//   wr_data_o     out 32  store data replicated into every lane
//   rd_addr_lo_i  in  2   byte offset of the load
//   rd_size_i     in  2   load size encoding
//   rd_unsigned_i in  1   1 = zero-extend, 0 = sign-extend
//   rd_word_i     in  32  raw word read from the array
//   rd_data_o     out 32  selected and extended load data
// ---------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  wr_addr_lo_i,
    input  logic [1:0]  wr_size_i,
    input  logic [31:0] wr_data_i,
    output logic [3:0]  wr_be_o,
    output logic [31:0] wr_data_o,
    input  logic [1:0]  rd_addr_lo_i,
    input  logic [1:0]  rd_size_i,
    input  logic        rd_unsigned_i,
    input  logic [31:0] rd_word_i,
    output logic [31:0] rd_data_o
);

    // Replicating the data lets the array write any enabled lane straight
    // from the same bit positions, with no per-lane multiplexing.
    always_comb begin
        wr_be_o   = lane_enable(wr_size_i, wr_addr_lo_i);
        wr_data_o = wr_data_i;
        case (wr_size_i)
            SZ_BYTE: wr_data_o = {4{wr_data_i[7:0]}};
            SZ_HALF: wr_data_o = {2{wr_data_i[15:0]}};
            default: wr_data_o = wr_data_i;
        endcase
        rd_data_o = load_extend(rd_word_i, rd_size_i, rd_addr_lo_i, rd_unsigned_i);
    end

endmodule

// File: rtl/data_memory_sync.sv
// ---------------------------------------------------------------------------
// data_memory_sync
// Clocked byte/halfword/word data memory with valid/ready request and
// response channels, configurable wait states and error reporting.
// Ports:
//   clk          in  1           rising-edge clock
//   reset        in  1           asynchronous active-high reset
//   req_valid    in  1           request present
//   req_ready    out 1           block can accept a request (IDLE only)
//   req_write    in  1           1 = store, 0 = load
//   req_size     in  2           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned in  1           loads: 1 = zero-extend
//   req_addr     in  ADDR_WIDTH  byte address
//   req_wdata    in  DATA_WIDTH  right-aligned store data
//   resp_valid   out 1           response present
//   resp_ready   in  1           consumer accepts the response
//   resp_rdata   out DATA_WIDTH  extended load data, 0 for stores/errors
//   resp_err     out 1           misaligned, out of range or illegal size
// ---------------------------------------------------------------------------
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = "dmem.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int         IDX_W    = ADDR_WIDTH - 2;
    localparam int         MEM_AW   = $clog2(DEPTH);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t                  state_q;
    logic [2:0]              cnt_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    err_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic [1:0]              addr_lo_q;
    logic                    unsigned_q;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]        word_idx;
    logic [MEM_AW-1:0]       mem_addr;
    logic                    out_of_range;
    logic                    misaligned;
    logic                    req_err;
    logic                    accept;
    logic [3:0]              wr_be;
    logic [31:0]             wr_data_rep;
    logic [31:0]             rd_ext;

    // Request decode: the range test is done at 64 bits so it stays correct
    // whatever the relation between ADDR_WIDTH and DEPTH.
    always_comb begin
        word_idx     = req_addr[ADDR_WIDTH-1:2];
        mem_addr     = word_idx[MEM_AW-1:0];
        out_of_range = (64'(word_idx) >= 64'(DEPTH));
        misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_err      = out_of_range || misaligned || (req_size == SZ_ILLEGAL);
        accept       = (state_q == ST_IDLE) && req_valid && req_ready_q;
    end

    dmem_lane_align u_align (
        .wr_addr_lo_i  (req_addr[1:0]),
        .wr_size_i     (req_size),
        .wr_data_i     (req_wdata),
        .wr_be_o       (wr_be),
        .wr_data_o     (wr_data_rep),
        .rd_addr_lo_i  (addr_lo_q),
        .rd_size_i     (size_q),
        .rd_unsigned_i (unsigned_q),
        .rd_word_i     (hold_q),
        .rd_data_o     (rd_ext)
    );

    // Array and holding register: neither is reset. Stores commit on the
    // accept edge; the raw word is captured on the same edge so a later
    // load always sees every store accepted before it.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_write && !req_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_be[i]) begin
                        mem_q[mem_addr][8*i +: 8] <= wr_data_rep[8*i +: 8];
                    end
                end
            end
            hold_q <= mem_q[mem_addr];
        end
    end

    // Transaction FSM. req_ready is raised one clock after reset release
    // and dropped on accept so requests never overlap; the request
    // attributes needed to form the response are captured at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            addr_lo_q    <= 2'b00;
            unsigned_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        write_q     <= req_write;
                        size_q      <= req_size;
                        addr_lo_q   <= req_addr[1:0];
                        unsigned_q  <= req_unsigned;
                        err_q       <= req_err;
                        if (WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Response data is formed only from registers captured at accept, so
    // it is stable for as long as resp_valid is held.
    always_comb begin
        req_ready  = req_ready_q;
        resp_valid = resp_valid_q;
        resp_err   = resp_valid_q && err_q;
        resp_rdata = (resp_valid_q && !err_q && !write_q) ? rd_ext : '0;
    end

endmodule

// File: tb/tb_data_memory_sync.sv
// ---------------------------------------------------------------------------
// tb_data_memory_sync
// Drives two instances (WAIT_STATES = 0 and WAIT_STATES = 3) and compares
// every response against a byte-array reference model of the memory.
// ---------------------------------------------------------------------------
module tb_data_memory_sync;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid    [2];
    logic        reqReady    [2];
    logic        reqWrite    [2];
    logic [1:0]  reqSize     [2];
    logic        reqUnsigned [2];
    logic [31:0] reqAddr     [2];
    logic [31:0] reqWdata    [2];
    logic        respValid   [2];
    logic        respReady   [2];
    logic [31:0] respRdata   [2];
    logic        respErr     [2];

    logic [7:0]  refMem [2][DEPTH*4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_sync #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
        .req_size(reqSize[0]), .req_unsigned(reqUnsigned[0]), .req_addr(reqAddr[0]),
        .req_wdata(reqWdata[0]), .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    data_memory_sync #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
        .req_size(reqSize[1]), .req_unsigned(reqUnsigned[1]), .req_addr(reqAddr[1]),
        .req_wdata(reqWdata[1]), .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    function automatic int waitOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic logic expErr(input logic [1:0] sz, input logic [31:0] a);
        int n;
        if (sz == 2'b11) return 1'b1;
        if ((a >> 2) >= 32'(DEPTH)) return 1'b1;
        n = 1 << sz;
        return (a % 32'(n)) != 0;
    endfunction

    function automatic logic [31:0] expLoad(input int d, input logic [1:0] sz,
                                            input logic un, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        if (expErr(sz, a)) return 32'h0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[d][int'(a) + i];
        if (!un && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic modelStore(input int d, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd);
        int n;
        if (!expErr(sz, a)) begin
            n = 1 << sz;
            for (int i = 0; i < n; i++) refMem[d][int'(a) + i] = wd[8*i +: 8];
        end
    endtask

    // One full transaction on instance d, holding resp_ready low for
    // holdCycles cycles after the response appears.
    task automatic applyStimulus(input int d, input logic wr, input logic [1:0] sz,
                                 input logic un, input logic [31:0] addr,
                                 input logic [31:0] wd, input int holdCycles,
                                 input string tag);
        logic [31:0] expData;
        logic        expE;
        int          lat;
        bit          ok;
        expE    = expErr(sz, addr);
        expData = wr ? 32'h0 : expLoad(d, sz, un, addr);
        @(negedge clk);
        reqValid[d]    = 1'b1;
        reqWrite[d]    = wr;
        reqSize[d]     = sz;
        reqUnsigned[d] = un;
        reqAddr[d]     = addr;
        reqWdata[d]    = wd;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (reqReady[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
            reqValid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        reqValid[d]    = 1'b0;
        reqAddr[d]     = $urandom;
        reqWdata[d]    = $urandom;
        reqSize[d]     = 2'($urandom);
        reqUnsigned[d] = 1'($urandom);
        reqWrite[d]    = 1'($urandom);
        if (wr) modelStore(d, sz, addr, wd);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (respValid[d]) begin
                ok = 1'b1;
                break;
            end
            checkOutput({tag, "_busy_ready"}, 32'(reqReady[d]), 32'd0);
        end
        if (!ok) begin
            checkOutput({tag, "_resp_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(1 + waitOf(d)));
        checkOutput({tag, "_err"}, 32'(respErr[d]), 32'(expE));
        checkOutput({tag, "_rdata"}, respRdata[d], expData);
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 32'(respValid[d]), 32'd1);
            checkOutput({tag, "_hold_rdata"}, respRdata[d], expData);
            checkOutput({tag, "_hold_err"}, 32'(respErr[d]), 32'(expE));
            checkOutput({tag, "_hold_ready"}, 32'(reqReady[d]), 32'd0);
        end
        respReady[d] = 1'b1;
        @(posedge clk);
        #1;
        respReady[d] = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_done_valid"}, 32'(respValid[d]), 32'd0);
        checkOutput({tag, "_done_ready"}, 32'(reqReady[d]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqSize[d] = 2'b00;
            reqUnsigned[d] = 1'b0; reqAddr[d] = 32'h0; reqWdata[d] = 32'h0;
            respReady[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_req_ready", 32'(reqReady[d]), 32'd0);
            checkOutput("rst_resp_valid", 32'(respValid[d]), 32'd0);
            checkOutput("rst_resp_rdata", respRdata[d], 32'd0);
            checkOutput("rst_resp_err", 32'(respErr[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("post_rst_ready", 32'(reqReady[d]), 32'd1);
            checkOutput("post_rst_valid", 32'(respValid[d]), 32'd0);
        end

        // Give every word a known value so random loads are fully predictable.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, "init");
            end
        end

        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h10, 32'hA01100AB, 0, "sw_10");
            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, "lw_10");

            applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 0, "sw_20");
            applyStimulus(d, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, "lb_21");
            applyStimulus(d, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 0, "lb_22");
            applyStimulus(d, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 0, "lbu_23");
            applyStimulus(d, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0, "lh_22");
            applyStimulus(d, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, "lhu_22");

            applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, 0, "sw_0");
            applyStimulus(d, 1'b1, 2'b00, 1'b0, 32'h1, 32'hDEADBEAA, 0, "sb_1");
            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, "lw_0_a");
            applyStimulus(d, 1'b1, 2'b01, 1'b0, 32'h2, 32'h1234BEEF, 0, "sh_2");
            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, "lw_0_b");

            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, "err_lw_6");
            applyStimulus(d, 1'b1, 2'b01, 1'b0, 32'h3, 32'h5555AAAA, 0, "err_sh_3");
            applyStimulus(d, 1'b1, 2'b11, 1'b0, 32'h0, 32'hCAFEF00D, 0, "err_sz11_st");
            applyStimulus(d, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 0, "err_sz11_ld");
            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, "err_lw_400");
            applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h400, 32'h0BADBEEF, 0, "err_sw_400");
            applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h6, 32'h0BADBEEF, 0, "err_sw_6");
            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, "unchanged_0");
            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, "unchanged_4");

            applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, "bp_lw_10");
        end

        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 200; t++) begin
                sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1024, 8191))
                                                  : 32'($urandom_range(0, 1023));
                applyStimulus(d, 1'($urandom), sz, 1'($urandom), a, $urandom,
                              $urandom_range(0, 2), "rand");
            end
        end

        // Reset while the store to 0x8 is waiting for its response.
        @(negedge clk);
        reqValid[1] = 1'b1; reqWrite[1] = 1'b1; reqSize[1] = 2'b10;
        reqUnsigned[1] = 1'b0; reqAddr[1] = 32'h8; reqWdata[1] = 32'h21101122;
        checkOutput("mid_rst_pre_ready", 32'(reqReady[1]), 32'd1);
        @(posedge clk);
        #1;
        reqValid[1] = 1'b0;
        modelStore(1, 2'b10, 32'h8, 32'h21101122);
        @(negedge clk);
        checkOutput("mid_rst_in_wait", 32'(respValid[1]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", 32'(respValid[1]), 32'd0);
        checkOutput("mid_rst_ready", 32'(reqReady[1]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_rel_valid", 32'(respValid[1]), 32'd0);
        checkOutput("mid_rst_rel_ready", 32'(reqReady[1]), 32'd1);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, "mid_rst_lw_8");
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, "other_lw_8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
